arb_grant_mux: RTL

- Consumer stage for the fixed-priority arbiter's one-hot grant.
- Collects NUM_PORTS valid/ready request streams and drives the arbiter's request vector. Uses the returned grant to select one port's payload and registers it into a single-entry output slot.
- Supports multi-beat bursts: once a port wins, the block stays locked to that port until its last beat is accepted. The arbiter is bypassed during the burst.
- Sits between requesting units (e.g. shader-core memory ports) and a shared downstream resource.

---
 rtl/arb_grant_mux.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/arb_grant_mux.sv
// -----------------------------------------------------------------------------
// arb_grant_mux
//
// Consumer stage for a fixed-priority arbiter. Presents the per-port request
// valids to the arbiter, uses the returned one-hot grant to pick one port's
// payload and registers it into a single-entry output slot. Multi-beat bursts
// lock the block to the winning port until its last beat is accepted; the
// arbiter is bypassed for the rest of the burst.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       synchronous active-low reset
//   req_valid_i  per-port request valid                  [NUM_PORTS]
//   req_data_i   per-port payload, port p at [p*DATA_W +: DATA_W]
//   req_last_i   per-port last-beat flag                  [NUM_PORTS]
//   req_ready_o  per-port accept, at most one bit set     [NUM_PORTS]
//   arb_req_o    request vector to the arbiter            [NUM_PORTS]
//   arb_gnt_i    one-hot grant from the arbiter (combinational return)
//   out_valid_o  output slot holds a beat
//   out_data_o   registered payload                       [DATA_W]
//   out_id_o     index of the source port                 [ID_W]
//   out_last_o   registered last flag
//   out_ready_i  downstream accept
//   locked_o     high while a burst holds the lock
// -----------------------------------------------------------------------------
module arb_grant_mux #(
  parameter  int NUM_PORTS = 16,
  parameter  int DATA_W    = 32,
  localparam int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_i,
  input  logic [NUM_PORTS-1:0]        req_last_i,
  output logic [NUM_PORTS-1:0]        req_ready_o,
  output logic [NUM_PORTS-1:0]        arb_req_o,
  input  logic [NUM_PORTS-1:0]        arb_gnt_i,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [ID_W-1:0]             out_id_o,
  output logic                        out_last_o,
  input  logic                        out_ready_i,
  output logic                        locked_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       lock_id_q, lock_id_d;

  logic                  can_load;
  logic                  accept;
  logic [NUM_PORTS-1:0]  gnt_valid;
  logic [NUM_PORTS-1:0]  sel;
  logic [ID_W-1:0]       sel_id;
  logic [DATA_W-1:0]     sel_data;
  logic                  sel_last;

  // The slot can take a new beat when empty or draining this cycle, which
  // gives one beat per cycle with no bubble.
  assign can_load  = rst_ni & (~out_valid_o | out_ready_i);

  // During a burst the arbiter sees no requests; its grant is ignored.
  assign arb_req_o = (rst_ni && state_q == IDLE) ? req_valid_i : '0;

  // A grant to a port that is not requesting selects nothing.
  assign gnt_valid = arb_gnt_i & req_valid_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel = '0;
    if (state_q == LOCKED) begin
      sel[lock_id_q] = 1'b1;
    end else begin
      // x & -x isolates the lowest set bit, so a malformed multi-hot grant
      // still resolves to the highest-priority (lowest-index) port.
      sel = gnt_valid & (~gnt_valid + NUM_PORTS'(1));
    end
  end

  assign req_ready_o = sel & {NUM_PORTS{can_load}};
  assign accept      = |(req_ready_o & req_valid_i);

  // Payload/last/index mux driven by the one-hot selection.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel[p]) begin
        sel_id   = ID_W'(p);
        sel_data = req_data_i[p*DATA_W +: DATA_W];
        sel_last = req_last_i[p];
      end
    end
  end

  // Lock on the first beat of a multi-beat request; release on its last beat.
  // A locked port that drops valid simply stalls the block.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (accept && !sel_last) begin
          state_d   = LOCKED;
          lock_id_d = sel_id;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lock_id_q   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= '0;
      out_last_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      if (accept) begin
        out_valid_o <= 1'b1;
        out_data_o  <= sel_data;
        out_id_o    <= sel_id;
        out_last_o  <= sel_last;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  assign locked_o = (state_q == LOCKED);

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == IDLE) |-> $onehot0(arb_gnt_i));

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_hold
    a_data_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[p] && !req_ready_o[p]) |=> $stable(req_data_i[p*DATA_W +: DATA_W]));
  end
`endif

endmodule
